// File: rtl/gate_lab.sv
// gate_lab: debounced push-button logic-gate demonstrator driving a 6-LED bank (active-low).
// Optional macro GATE_LAB_AUTO_EN adds a timed auto-advance of the gate mode while idle.
module gate_lab #(
  parameter int NUM_IN      = 2,
  parameter int DB_CYCLES   = 270000,
  parameter int AUTO_CYCLES = 27000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_IN-1:0] btn_n,
  input  logic              mode_btn_n,
  output logic [5:0]        led
);

  // mode | meaning
  // 0    | AND
  // 1    | OR
  // 2    | NAND (reset)
  // 3    | NOR
  // 4    | XOR  (odd parity)
  // 5    | XNOR (even parity)
  // 6,7  | unreachable; evaluates NAND, next advance goes to 0

  localparam int NB = NUM_IN + 1;
  localparam int DW = $clog2(DB_CYCLES);
  localparam logic [DW-1:0] DB_MAX = DW'(DB_CYCLES - 1);

  localparam logic [2:0] M_AND  = 3'd0;
  localparam logic [2:0] M_OR   = 3'd1;
  localparam logic [2:0] M_NAND = 3'd2;
  localparam logic [2:0] M_NOR  = 3'd3;
  localparam logic [2:0] M_XOR  = 3'd4;
  localparam logic [2:0] M_XNOR = 3'd5;

  // Channel NUM_IN is the mode button; lower channels are the gate inputs.
  logic [NB-1:0]     raw;
  logic [NB-1:0]     sync1;
  logic [NB-1:0]     sync2;
  logic [NB-1:0]     stable;
  logic [NB-1:0]     accept;
  logic [NUM_IN-1:0] pressed;
  logic              mode_rise;
  logic              auto_tick;
  logic              advance;
  logic [2:0]        mode_q;
  logic [2:0]        mode_d;
  logic              result;
  logic [5:0]        led_d;

  assign raw = ~{mode_btn_n, btn_n};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < NB; i++) begin : g_db
    logic [DW-1:0] cnt;
    logic          st;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= '0;
        st  <= 1'b0;
      end else if (sync2[i] == st) begin
        cnt <= '0;
      end else if (cnt == DB_MAX) begin
        cnt <= '0;
        st  <= sync2[i];
      end else begin
        cnt <= cnt + DW'(1);
      end
    end

    assign stable[i] = st;
    assign accept[i] = (sync2[i] != st) && (cnt == DB_MAX);
  end

  assign pressed = stable[NUM_IN-1:0];

  // Advancing on the accepting edge keeps mode and debounced inputs in lockstep,
  // so a simultaneous change shows up in a single led update.
  assign mode_rise = accept[NUM_IN] & sync2[NUM_IN];

`ifdef GATE_LAB_AUTO_EN
  localparam int AW = $clog2(AUTO_CYCLES);
  localparam logic [AW-1:0] AUTO_MAX = AW'(AUTO_CYCLES - 1);

  logic [AW-1:0] auto_cnt;
  logic          any_pressed;

  assign any_pressed = |stable;
  assign auto_tick   = !any_pressed && (auto_cnt == AUTO_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      auto_cnt <= '0;
    end else if (any_pressed || (auto_cnt == AUTO_MAX)) begin
      auto_cnt <= '0;
    end else begin
      auto_cnt <= auto_cnt + AW'(1);
    end
  end
`else
  assign auto_tick = 1'b0;
`endif

  assign advance = mode_rise | auto_tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= M_NAND;
    end else begin
      mode_q <= mode_d;
    end
  end

  always_comb begin
    mode_d = mode_q;
    if (advance) begin
      if (mode_q >= M_XNOR) begin
        mode_d = M_AND;
      end else begin
        mode_d = mode_q + 3'd1;
      end
    end
  end

  always_comb begin
    result = ~&pressed;
    case (mode_q)
      M_AND:   result = &pressed;
      M_OR:    result = |pressed;
      M_NAND:  result = ~&pressed;
      M_NOR:   result = ~|pressed;
      M_XOR:   result = ^pressed;
      M_XNOR:  result = ~^pressed;
      default: result = ~&pressed;
    endcase
    led_d = {~pressed[1], ~pressed[0], ~mode_q, ~result};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led <= 6'b111111;
    end else begin
      led <= led_d;
    end
  end

endmodule

// File: doc/gate_lab.md
Name: gate_lab

Overview:
- Parametrised, debounced logic-gate demonstrator for the board's push-buttons and 6-LED bank.
- N active-low input buttons feed a selectable gate function: AND, OR, NAND, NOR, XOR or XNOR.
- A dedicated mode button cycles the function. LEDs show the gate result, the current mode code and the debounced input state.
- Replaces single-gate, purely combinational board tops with one registered, glitch-free block.

Parameters:
- NUM_IN, 2, number of gate input buttons; legal range 2..8.
- DB_CYCLES, 270000, consecutive stable clock cycles required to accept a button change (10 ms at 27 MHz); minimum 2.
- AUTO_CYCLES, 27000000, auto-advance period in cycles; used only when GATE_LAB_AUTO_EN is defined.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- btn_n  input  NUM_IN  gate input buttons, active-low (0 = pressed = logic 1), asynchronous to clk
- mode_btn_n  input  1  mode-select button, active-low, asynchronous
- led  output  6  LED bank, active-low (0 = lit)

Behaviour:
- Reset: clk and rst_n only; rst_n is asynchronous assert, synchronous deassert handled upstream.
  - While rst_n = 0: all synchronisers and debounced states = 0 (not pressed), debounce counters = 0, mode = 2 (NAND), led = 6'b111111 (all off).
  - Reset asserted mid-debounce or mid-press discards all pending state immediately.
- Synchronisation: every button (btn_n[i], mode_btn_n) passes through a 2-flop synchroniser. It is inverted to active-high "pressed" before or after the flops.
- Debounce, per button, independent counter:
  - synced == stable: counter <= 0.
  - synced != stable and counter < DB_CYCLES-1: counter increments.
  - synced != stable and counter == DB_CYCLES-1: stable <= synced, counter <= 0.
  - Net effect: stable changes only after synced has differed for DB_CYCLES consecutive cycles. Any pulse shorter than DB_CYCLES cycles is ignored.
- Mode register (3 bits):
  - Codes: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR (odd parity over all NUM_IN inputs), 5 XNOR (even parity).
  - A rising edge of debounced mode-pressed advances mode by 1; 5 wraps to 0.
  - Holding the button gives exactly one advance; the release edge does nothing.
  - Codes 6 and 7 are unreachable. If ever present, the block evaluates NAND and the next advance goes to 0.
- Gate evaluation is combinational from the debounced inputs and the mode, then registered into led:
  - led[0] = ~result (lit when the gate output is 1).
  - led[3:1] = ~mode.
  - led[4] = ~pressed[0], led[5] = ~pressed[1].
  - Inputs beyond index 1 have no LED.
- Latency, pin edge to led change: 2 (sync) + DB_CYCLES (debounce) + 1 (output register) cycles.
- Mode change in the same cycle as an input change: both take effect in the same led update; no intermediate value is shown.
- First led update after reset deassertion occurs on the first clk edge. The result for all-released in NAND mode is 1, so led = 6'b111010 (led[0] lit; mode 2 → led[3:1] = ~3'b010 = 101; led[5:4] = 11 off).

Optional Feature:
- Macro: GATE_LAB_AUTO_EN.
- Defined:
  - A free-running counter advances mode by 1 (with wrap) every AUTO_CYCLES cycles while no gate or mode button is debounced-pressed.
  - Any debounced press resets the counter to 0.
  - A mode-button edge and an auto tick in the same cycle advance mode by exactly 1.
  - Counter reset value 0.
- Undefined: no auto counter exists; mode changes only on mode-button edges. AUTO_CYCLES is ignored.

Test Plan:
1. Reset then release, all buttons released (NUM_IN=2, DB_CYCLES=4): one cycle after deassert → led = 6'b111010; stays constant.
2. Drive btn_n = 2'b00 steady: after 2+4+1 = 7 cycles → led[0] = 1 (NAND 1,1 = 0, LED off) and led[5:4] = 2'b00; led[3:1] unchanged.
3. Glitch btn_n[0] low for 3 cycles, then high → led unchanged throughout. A 4-cycle low → debounced press accepted and led[4] = 0.
4. Press mode button 4 times, each held 10 cycles, from mode 2 → mode sequence 3, 4, 5, 0; led[3:1] = 3'b100, 011, 010, 111. Holding 50 cycles advances once only.
5. Mode 4 (XOR) with inputs (1,0) → led[0] = 0; inputs (1,1) → led[0] = 1. Assert rst_n = 0 mid-debounce → led = 6'b111111 immediately and mode = 2 after release.
6. GATE_LAB_AUTO_EN defined, AUTO_CYCLES=20, no presses: mode advances every 20 cycles, 2→3→4. A press at cycle 15 restarts the count, so the next advance is 20 cycles after release debounces.
